// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared constants and the {pc,inst} entry type for the fetch stage
package if_fetch_pkg;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_t;
endpackage

// File: rtl/if_fetch_if.sv
// if_fetch_if: instruction memory request/response bus between fetch (master) and memory (slave)
interface if_fetch_if;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  modport master (output o_imem_req, o_imem_addr, input i_imem_gnt, i_imem_rvalid, i_imem_rdata);
  modport slave  (input o_imem_req, o_imem_addr, output i_imem_gnt, i_imem_rvalid, i_imem_rdata);
endinterface

// File: rtl/if_fifo.sv
// if_fifo: synchronous {pc,inst} FIFO with push/pop/clear and occupancy count
module if_fifo
  import if_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic    i_clk,
  input  logic    i_reset,
  input  logic    i_push,
  input  logic    i_pop,
  input  logic    i_clear,
  input  fetch_t  i_data,
  output fetch_t  o_data,
  output logic [AW:0] o_count
);
  fetch_t r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  // pointers and count; clear empties the queue in one cycle
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      r_wr  <= r_wr + AW'(i_push);
      r_rd  <= r_rd + AW'(i_pop);
      r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end
  // storage needs no reset; occupancy decides what is valid
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr] <= i_data;
  end
  assign o_data  = r_mem[r_rd];
  assign o_count = r_cnt;
endmodule

// File: rtl/if_fetch.sv
// if_fetch: PC, pipelined imem requests, response FIFO and IF/ID register (optional IF_MISALIGN_CHECK_EN)
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] NOP_INST   = INST_NOP
) (
  input  logic        i_clk,
  input  logic        i_reset,
  if_fetch_if.master  imem,
  input  logic        i_stall,
  input  logic        i_jump_flag,
  input  logic [31:0] i_jump_addr,
  output logic [31:0] o_pc_addr,
  output logic [31:0] o_inst_data,
  output logic        o_inst_valid
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic        o_misalign
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [31:0]   r_pc, r_pc_addr, r_inst_data;
  logic          r_inst_valid;
  logic [CW-1:0] r_inflight, r_kill, w_cnt;
  logic          w_fire, w_rv, w_take, w_adv, w_empty, w_pop, w_bypass, w_push;
  fetch_t        w_in, w_head;
  assign imem.o_imem_req  = !i_reset && !i_jump_flag &&
                            (({1'b0, r_inflight} + {1'b0, w_cnt}) < (CW+1)'(FIFO_DEPTH));
  assign imem.o_imem_addr = r_pc;
  assign w_fire   = imem.o_imem_req && imem.i_imem_gnt;
  assign w_rv     = imem.i_imem_rvalid;
  assign w_take   = w_rv && r_kill == '0 && !i_jump_flag;
  assign w_in     = '{pc: r_pc - 32'({r_inflight, 2'b00}), inst: imem.i_imem_rdata};
  assign w_adv    = !i_jump_flag && !i_stall;
  assign w_empty  = w_cnt == '0;
  assign w_pop    = w_adv && !w_empty;
  assign w_bypass = w_adv && w_empty && w_take;
  assign w_push   = w_take && !w_bypass;
  if_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (i_jump_flag),
    .i_data  (w_in),
    .o_data  (w_head),
    .o_count (w_cnt)
  );
  // pc, in-flight count and number of stale responses still to discard
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc       <= RESET_PC;
      r_inflight <= '0;
      r_kill     <= '0;
    end else begin
      r_pc       <= i_jump_flag ? (i_jump_addr & 32'hFFFF_FFFC) : (w_fire ? r_pc + 32'd4 : r_pc);
      r_inflight <= r_inflight + CW'(w_fire) - CW'(w_rv);
      r_kill     <= i_jump_flag ? r_inflight - CW'(w_rv) : r_kill - CW'(w_rv && r_kill != '0);
    end
  end
  // IF/ID register: flush beats stall; an empty FIFO lets a fresh response through directly
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc_addr    <= ZERO_WORD;
      r_inst_data  <= NOP_INST;
      r_inst_valid <= 1'b0;
    end else if (i_jump_flag) begin
      r_inst_data  <= NOP_INST;
      r_inst_valid <= 1'b0;
    end else if (!i_stall) begin
      r_pc_addr    <= w_pop ? w_head.pc : (w_bypass ? w_in.pc : r_pc_addr);
      r_inst_data  <= w_pop ? w_head.inst : (w_bypass ? w_in.inst : NOP_INST);
      r_inst_valid <= w_pop || w_bypass;
    end
  end
  assign o_pc_addr    = r_pc_addr;
  assign o_inst_data  = r_inst_data;
  assign o_inst_valid = r_inst_valid;
`ifdef IF_MISALIGN_CHECK_EN
  logic r_misalign;
  // one-cycle flag for a redirect target that is not word aligned
  always_ff @(posedge i_clk) begin
    r_misalign <= !i_reset && i_jump_flag && (i_jump_addr[1:0] != 2'b00);
  end
  assign o_misalign = r_misalign;
`endif
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed checks of if_fetch against a queued in-order instruction memory model
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_stall = 1'b0;
  logic        i_jump_flag = 1'b0;
  logic [31:0] i_jump_addr = 32'h0;
  logic [31:0] o_pc_addr, o_inst_data;
  logic        o_inst_valid;
`ifdef IF_MISALIGN_CHECK_EN
  logic        o_misalign;
`endif
  logic        gnt = 1'b1;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'h0;
  int          lat = 1;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  typedef struct {
    logic [31:0] a;
    int          t;
  } mreq_t;
  mreq_t mq[$];

  if_fetch_if bus ();
  assign bus.i_imem_gnt    = gnt;
  assign bus.i_imem_rvalid = rvalid;
  assign bus.i_imem_rdata  = rdata;

  if_fetch dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .imem         (bus),
    .i_stall      (i_stall),
    .i_jump_flag  (i_jump_flag),
    .i_jump_addr  (i_jump_addr),
    .o_pc_addr    (o_pc_addr),
    .o_inst_data  (o_inst_data),
    .o_inst_valid (o_inst_valid)
`ifdef IF_MISALIGN_CHECK_EN
    ,
    .o_misalign   (o_misalign)
`endif
  );

  always #5 clk = ~clk;

  // memory: responds in order, lat cycles after the granted request, word = {C0DE, addr[15:0]}
  always @(posedge clk) begin
    cyc++;
    #1;
    if (mq.size() > 0 && mq[0].t + lat <= cyc) begin
      rvalid = 1'b1;
      rdata  = {16'hC0DE, mq[0].a[15:0]};
    end else begin
      rvalid = 1'b0;
      rdata  = 32'h0;
    end
  end
  always @(negedge clk) begin
    if (i_reset) mq.delete();
    else begin
      if (rvalid) void'(mq.pop_front());
      if (bus.o_imem_req && gnt) mq.push_back('{a: bus.o_imem_addr, t: cyc});
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    repeat (3) begin
      tick;
      chk("rst_req", 32'(bus.o_imem_req), 32'h0);
      chk("rst_inst", o_inst_data, 32'h13);
      chk("rst_valid", 32'(o_inst_valid), 32'h0);
      chk("rst_pc", o_pc_addr, 32'h0);
    end
    tick;
    i_reset = 1'b0;
    #1;
    chk("first_req", 32'(bus.o_imem_req), 32'h1);
    chk("first_addr", bus.o_imem_addr, 32'h0);
    tick;
    chk("lat_valid0", 32'(o_inst_valid), 32'h0);
    chk("second_addr", bus.o_imem_addr, 32'h4);
    tick;
    chk("s_pc0", o_pc_addr, 32'h0);
    chk("s_inst0", o_inst_data, 32'hC0DE_0000);
    chk("s_valid0", 32'(o_inst_valid), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      tick;
      chk("s_pc", o_pc_addr, 32'(4 * i));
      chk("s_inst", o_inst_data, 32'hC0DE_0000 + 32'(4 * i));
      chk("s_valid", 32'(o_inst_valid), 32'h1);
    end
    i_stall = 1'b1;
    tick;
    chk("stall_pc", o_pc_addr, 32'h10);
    chk("stall_valid", 32'(o_inst_valid), 32'h1);
    chk("stall_req", 32'(bus.o_imem_req), 32'h1);
    chk("stall_addr", bus.o_imem_addr, 32'h1C);
    tick;
    chk("stall_addr2", bus.o_imem_addr, 32'h20);
    tick;
    chk("credit_stop", 32'(bus.o_imem_req), 32'h0);
    tick;
    chk("credit_stop2", 32'(bus.o_imem_req), 32'h0);
    chk("stall_inst", o_inst_data, 32'hC0DE_0010);
    tick;
    i_stall = 1'b0;
    #1;
    chk("no_pop_credit", 32'(bus.o_imem_req), 32'h0);
    chk("stall_pc_end", o_pc_addr, 32'h10);
    tick;
    chk("resume_pc", o_pc_addr, 32'h14);
    chk("resume_req", 32'(bus.o_imem_req), 32'h1);
    chk("resume_addr", bus.o_imem_addr, 32'h24);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("order_pc", o_pc_addr, 32'h18 + 32'(4 * i));
      chk("order_inst", o_inst_data, 32'hC0DE_0018 + 32'(4 * i));
      chk("order_valid", 32'(o_inst_valid), 32'h1);
    end
    i_reset = 1'b1;
    lat = 3;
    tick;
    chk("rst2_valid", 32'(o_inst_valid), 32'h0);
    chk("rst2_pc", o_pc_addr, 32'h0);
    i_reset = 1'b0;
    #1;
    chk("rst2_addr", bus.o_imem_addr, 32'h0);
    tick;
    chk("l3_addr1", bus.o_imem_addr, 32'h4);
    tick;
    chk("l3_addr2", bus.o_imem_addr, 32'h8);
    tick;
    i_jump_flag = 1'b1;
    i_jump_addr = 32'h100;
    #1;
    chk("jump_no_req", 32'(bus.o_imem_req), 32'h0);
    tick;
    i_jump_flag = 1'b0;
    #1;
    chk("jump_addr", bus.o_imem_addr, 32'h100);
    chk("jump_req", 32'(bus.o_imem_req), 32'h1);
    chk("kill_valid1", 32'(o_inst_valid), 32'h0);
    tick;
    chk("kill_valid2", 32'(o_inst_valid), 32'h0);
    tick;
    chk("kill_valid3", 32'(o_inst_valid), 32'h0);
    tick;
    chk("kill_valid4", 32'(o_inst_valid), 32'h0);
    tick;
    chk("tgt_pc", o_pc_addr, 32'h100);
    chk("tgt_inst", o_inst_data, 32'hC0DE_0100);
    chk("tgt_valid", 32'(o_inst_valid), 32'h1);
    tick;
    chk("tgt_pc2", o_pc_addr, 32'h104);
    chk("tgt_valid2", 32'(o_inst_valid), 32'h1);
    i_jump_flag = 1'b1;
    i_stall = 1'b1;
    i_jump_addr = 32'h200;
    tick;
    i_jump_flag = 1'b0;
    i_stall = 1'b0;
    #1;
    chk("flush_valid", 32'(o_inst_valid), 32'h0);
    chk("flush_inst", o_inst_data, 32'h13);
    chk("flush_pc_hold", o_pc_addr, 32'h104);
    chk("flush_addr", bus.o_imem_addr, 32'h200);
    chk("flush_req", 32'(bus.o_imem_req), 32'h1);
    tick;
    i_jump_flag = 1'b1;
    i_jump_addr = 32'h102;
    tick;
    i_jump_flag = 1'b0;
    #1;
    chk("mis_addr", bus.o_imem_addr, 32'h100);
`ifdef IF_MISALIGN_CHECK_EN
    chk("mis_flag", 32'(o_misalign), 32'h1);
`endif
    tick;
`ifdef IF_MISALIGN_CHECK_EN
    chk("mis_flag_clr", 32'(o_misalign), 32'h0);
`endif
    chk("mis_valid", 32'(o_inst_valid), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
